// File: rtl/hub75_pkg.sv
// hub75_pkg
// Shared constants for the HUB75 bit-plane fetch stage:
//   DEF_BITDEPTH / PIXBITS / PLANEBITS : default colour depth and derived widths
//   CH_R / CH_G / CH_B                 : channel index inside a packed {R,G,B} pixel
//                                        (bit offset = index * bitdepth)
//   PIX_TOP / PIX_BOT                  : pixel index inside the framebuffer word
//   FIFO_DEPTH                         : skid-buffer depth (3 when HUB75_GAMMA_EN is
//                                        defined, otherwise 2)
//   gamma_curve()                      : gamma table contents used by hub75_gamma_lut
package hub75_pkg;

  localparam int DEF_BITDEPTH = 8;
  localparam int PIXBITS      = 3 * DEF_BITDEPTH;
  localparam int PLANEBITS    = $clog2(DEF_BITDEPTH);

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  localparam int PIX_TOP = 0;
  localparam int PIX_BOT = 1;

`ifdef HUB75_GAMMA_EN
  localparam int FIFO_DEPTH = 3;
`else
  localparam int FIFO_DEPTH = 2;
`endif

  // Square-law curve (gamma 2.0), normalised so 0xFF maps to 0xFF.
  function automatic logic [7:0] gamma_curve(input logic [7:0] x);
    logic [15:0] sq;
    sq = {8'd0, x} * {8'd0, x};
    return 8'(sq / 16'd255);
  endfunction

endpackage

// File: rtl/hub75_gamma_lut.sv
// hub75_gamma_lut
// Registered 8-bit gamma ROM; output is valid one clock after the input.
// Only built when HUB75_GAMMA_EN is defined (the linear build has no use for it).
// Ports:
//   clk     : system clock
//   lut_in  : linear 8-bit channel value
//   lut_out : gamma-corrected value, registered
`ifdef HUB75_GAMMA_EN
module hub75_gamma_lut
  import hub75_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] lut_in,
  output logic [7:0] lut_out
);

  logic [7:0] lut_q;
  logic [7:0] lut_d;

  always_comb lut_d = gamma_curve(lut_in);

  // Pure data path: no reset, consumers qualify it with their own valid.
  always_ff @(posedge clk) lut_q <= lut_d;

  assign lut_out = lut_q;

endmodule
`endif

// File: rtl/hub75_bcm_fetch.sv
// hub75_bcm_fetch
// Pixel-fetch / bit-plane stage between the HUB75 scan driver and output stage.
// A request (row, col, plane) reads the top/bottom pixel pair from a synchronous
// framebuffer, the requested plane bit of each colour is sliced out and queued
// in a small skid FIFO whose head drives rgb1/rgb2.
// Optional macro HUB75_GAMMA_EN: channels pass through a registered gamma LUT,
// adding one pipeline stage and one FIFO entry.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready, req_row, req_col, req_plane : request handshake
//   fb_rd_en, fb_addr, fb_rdata                      : framebuffer read port
//   out_valid/out_ready, rgb1 (top), rgb2 (bottom)   : output handshake
module hub75_bcm_fetch
  import hub75_pkg::*;
#(
  parameter int ROWBITS  = 5,
  parameter int COLBITS  = 6,
  parameter int BITDEPTH = DEF_BITDEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ROWBITS-1:0]          req_row,
  input  logic [COLBITS-1:0]          req_col,
  input  logic [$clog2(BITDEPTH)-1:0] req_plane,
  output logic                        fb_rd_en,
  output logic [ROWBITS+COLBITS-1:0]  fb_addr,
  input  logic [6*BITDEPTH-1:0]       fb_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2:0]                  rgb1,
  output logic [2:0]                  rgb2
);

  localparam int PLW  = $clog2(BITDEPTH);
  localparam int PIXW = 3 * BITDEPTH;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PLW-1:0] PLANE_MAX = PLW'(BITDEPTH - 1);

  logic              rdy_en_q, rdy_en_d;
  logic              s1_valid_q, s1_valid_d;
  logic [PLW-1:0]    s1_plane_q, s1_plane_d;
  logic [PLW-1:0]    plane_clamped;
  logic [2:0]        used;
  logic              slice_valid;
  logic [PLW-1:0]    slice_plane;
  logic [2*PIXW-1:0] slice_pix;
  logic [5:0]        slice_rgb;
  logic [5:0]        mem_q [FIFO_DEPTH];
  logic [5:0]        mem_d [FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [5:0]        hold_q, hold_d;
  logic              push, pop;

  // Clamp only matters when the plane field can encode more than BITDEPTH values.
  if ((1 << PLW) > BITDEPTH) begin : g_clamp
    assign plane_clamped = (req_plane > PLANE_MAX) ? PLANE_MAX : req_plane;
  end else begin : g_noclamp
    assign plane_clamped = req_plane;
  end

`ifdef HUB75_GAMMA_EN
  logic              s2_valid_q, s2_valid_d;
  logic [PLW-1:0]    s2_plane_q, s2_plane_d;
  logic [2*PIXW-1:0] lut_pix;

  for (genvar k = 0; k < 6; k++) begin : g_lut
    hub75_gamma_lut u_lut (
      .clk     (clk),
      .lut_in  (fb_rdata[8*k +: 8]),
      .lut_out (lut_pix[8*k +: 8])
    );
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_plane_d = s1_valid_q ? s1_plane_q : s2_plane_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_plane_q <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_plane_q <= s2_plane_d;
    end
  end

  assign slice_valid = s2_valid_q;
  assign slice_plane = s2_plane_q;
  assign slice_pix   = lut_pix;
`else
  assign slice_valid = s1_valid_q;
  assign slice_plane = s1_plane_q;
  assign slice_pix   = fb_rdata;
`endif

  // Credit: every accepted read is guaranteed a FIFO slot because the RAM
  // pipeline cannot stall. Built from registers only, so out_ready never
  // reaches req_ready combinationally; the price is that a full pipeline
  // waits one cycle for a pop to be reflected in the count.
  always_comb begin
    used = 3'(count_q) + 3'(s1_valid_q);
`ifdef HUB75_GAMMA_EN
    used = used + 3'(s2_valid_q);
`endif
    req_ready = rdy_en_q && (used < 3'(FIFO_DEPTH));
  end

  assign fb_rd_en = req_valid && req_ready;
  assign fb_addr  = {req_row, req_col};

  always_comb begin
    rdy_en_d   = 1'b1;
    s1_valid_d = fb_rd_en;
    s1_plane_d = fb_rd_en ? plane_clamped : s1_plane_q;
  end

  function automatic logic [2:0] plane_bits(input logic [PIXW-1:0] pix,
                                            input logic [PLW-1:0]  p);
    logic [BITDEPTH-1:0] r, g, b;
    r = pix[CH_R*BITDEPTH +: BITDEPTH];
    g = pix[CH_G*BITDEPTH +: BITDEPTH];
    b = pix[CH_B*BITDEPTH +: BITDEPTH];
    return {r[p], g[p], b[p]};
  endfunction

  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_comb begin
    slice_rgb[2:0] = plane_bits(slice_pix[PIX_TOP*PIXW +: PIXW], slice_plane);
    slice_rgb[5:3] = plane_bits(slice_pix[PIX_BOT*PIXW +: PIXW], slice_plane);
  end

  // Skid FIFO; hold_q keeps the last popped pair so rgb is stable when empty.
  always_comb begin
    push     = slice_valid;
    pop      = out_valid && out_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    if (push) begin
      mem_d[wr_ptr_q] = slice_rgb;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      hold_d   = mem_q[rd_ptr_q];
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    count_d = count_q + CNTW'(push) - CNTW'(pop);
  end

  assign out_valid = (count_q != '0);
  assign rgb1      = out_valid ? mem_q[rd_ptr_q][2:0] : hold_q[2:0];
  assign rgb2      = out_valid ? mem_q[rd_ptr_q][5:3] : hold_q[5:3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_plane_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      s1_valid_q <= s1_valid_d;
      s1_plane_q <= s1_plane_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_hub75_bcm_fetch.sv
// tb_hub75_bcm_fetch
// Directed bench for hub75_bcm_fetch with a transaction-level model: each
// accepted request is turned into its expected rgb pair straight from the
// framebuffer contents, queued with the cycle it may first appear, and checked
// against the DUT every cycle. Literal expectations pin the model.
module tb_hub75_bcm_fetch;

  localparam int ROWBITS  = 5;
  localparam int COLBITS  = 6;
  localparam int BITDEPTH = 8;
`ifdef HUB75_GAMMA_EN
  localparam int LAT   = 3;
  localparam int DEPTH = 3;
  localparam logic [2:0] P7_R1 = 3'b100, P7_R2 = 3'b010;
  localparam logic [2:0] P0_R1 = 3'b100, P0_R2 = 3'b010;
`else
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
  localparam logic [2:0] P7_R1 = 3'b101, P7_R2 = 3'b010;
  localparam logic [2:0] P0_R1 = 3'b100, P0_R2 = 3'b011;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_row = '0;
  logic [5:0]  req_col = '0;
  logic [2:0]  req_plane = '0;
  logic        fb_rd_en;
  logic [10:0] fb_addr;
  logic [47:0] fb_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  rgb1, rgb2;

  int tests = 0;
  int fails = 0;
  int n_rd  = 0;
  int n_pop = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  hub75_bcm_fetch #(.ROWBITS(ROWBITS), .COLBITS(COLBITS), .BITDEPTH(BITDEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_plane (req_plane),
    .fb_rd_en  (fb_rd_en),
    .fb_addr   (fb_addr),
    .fb_rdata  (fb_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rgb1      (rgb1),
    .rgb2      (rgb2)
  );

  // Synchronous framebuffer: request sampled mid-cycle, data one edge later.
  logic [47:0] fb_mem [0:2047];
  logic        rd_pend = 1'b0;
  logic [10:0] rd_addr = '0;
  always @(negedge clk) begin
    rd_pend = fb_rd_en;
    rd_addr = fb_addr;
  end
  always @(posedge clk) if (rd_pend) fb_rdata <= fb_mem[rd_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan_map(input logic [7:0] v);
`ifdef HUB75_GAMMA_EN
    int sq;
    sq = int'(v) * int'(v);
    return 8'(sq / 255);
`else
    return v;
`endif
  endfunction

  function automatic logic [2:0] exp_bits(input logic [23:0] pix, input int plane);
    logic [7:0] r, g, b;
    int p;
    p = (plane > BITDEPTH - 1) ? BITDEPTH - 1 : plane;
    r = chan_map(pix[23:16]);
    g = chan_map(pix[15:8]);
    b = chan_map(pix[7:0]);
    return {r[p], g[p], b[p]};
  endfunction

  typedef struct {
    logic [2:0] r1;
    logic [2:0] r2;
    int         due;
  } exp_t;
  exp_t q[$];
  logic [2:0] last_r1 = '0, last_r2 = '0;

  // Accepting becomes possible only after a clock edge seen out of reset.
  logic armed = 1'b0;
  always @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy, exp_ov;
    logic [47:0] w;
    cyc++;
    if (!reset) begin
      q.delete();
      last_r1 = '0;
      last_r2 = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_fb_rd_en", fb_rd_en, 0);
      chk("rst_rgb", {rgb2, rgb1}, 0);
    end else begin
      exp_rdy = armed && (q.size() < DEPTH);
      exp_ov  = (q.size() > 0) && (q[0].due <= cyc);
      chk("req_ready", req_ready, exp_rdy);
      chk("fb_rd_en", fb_rd_en, req_valid && exp_rdy);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("rgb1", rgb1, q[0].r1);
        chk("rgb2", rgb2, q[0].r2);
      end else begin
        chk("rgb1_hold", rgb1, last_r1);
        chk("rgb2_hold", rgb2, last_r2);
      end
      if (fb_rd_en) n_rd++;
      if (req_valid && exp_rdy) begin
        chk("fb_addr", fb_addr, {req_row, req_col});
        w = fb_mem[{req_row, req_col}];
        e.r1  = exp_bits(w[23:0], int'(req_plane));
        e.r2  = exp_bits(w[47:24], int'(req_plane));
        e.due = cyc + LAT;
        q.push_back(e);
      end
      if (exp_ov && out_ready) begin
        last_r1 = q[0].r1;
        last_r2 = q[0].r2;
        void'(q.pop_front());
        n_pop++;
      end
    end
  end

  task automatic send(input int row, input int col, input int plane);
    logic acc;
    acc       = 1'b0;
    req_row   = 5'(row);
    req_col   = 6'(col);
    req_plane = 3'(plane);
    req_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string nm, input logic [2:0] e1, input logic [2:0] e2);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk({nm, "_early"}, out_valid, 0);
    end
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_rgb1"}, rgb1, e1);
    chk({nm, "_rgb2"}, rgb2, e2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] tmp;
    int n0, p0, acc, stale;
    for (int i = 0; i < 2048; i++) begin
      tmp = {$urandom(), $urandom()};
      fb_mem[i] = tmp[47:0];
    end
    fb_mem[{5'd1, 6'd2}] = {24'h00FF01, 24'hFF0080};

    // Reset release
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_rgb", {rgb2, rgb1}, 6'b000000);
    chk("t1_ready_in_reset", req_ready, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t1_ready_before_edge", req_ready, 0);
    @(negedge clk);
    chk("t1_ready_after_edge", req_ready, 1);
    @(posedge clk);
    #1;

    // Single fetch, planes 7 and 0
    send(1, 2, 7);
    check_latency("t2_plane7", P7_R1, P7_R2);
    drain();
    send(1, 2, 0);
    check_latency("t2_plane0", P0_R1, P0_R2);
    drain();

    // Back-to-back column sweep
    n0 = n_rd;
    p0 = n_pop;
    for (int c = 0; c < 64; c++) send(3, c, c % 8);
    drain();
    chk("t3_rd_cycles", n_rd - n0, 64);
    chk("t3_outputs", n_pop - p0, 64);

    // Backpressure: five requests pending, out_ready low
    out_ready = 1'b0;
    p0 = n_pop;
    acc = 0;
    req_row = 5'd7;
    req_plane = 3'd5;
    req_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      req_col = 6'(acc);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("t4_accepted", acc, DEPTH);
    @(negedge clk);
    chk("t4_ready_low", req_ready, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int c = acc; c < 5; c++) send(7, c, 5);
    drain();
    chk("t4_outputs", n_pop - p0, 5);

    // Reset with one entry buffered and one read in flight
    out_ready = 1'b0;
    send(9, 10, 3);
    send(9, 11, 4);
    repeat (LAT - 2) begin
      @(posedge clk);
      #1;
    end
    chk("t5_valid_before", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("t5_valid_async", out_valid, 0);
    chk("t5_rgb_async", {rgb2, rgb1}, 6'b000000);
    chk("t5_ready_async", req_ready, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("t5_no_stale", stale, 0);
    @(posedge clk);
    #1;
    p0 = n_pop;
    send(9, 12, 6);
    drain();
    chk("t5_fresh_output", n_pop - p0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
